// File: rtl/prog_loader.sv
// Boot-stage program loader: frames a byte stream into the CPU program memory and releases CPU reset.
// Optional trailer checksum is compiled in with `define LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter logic [12:0] BASE_ADDR = 13'h0000,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        halt,
    output logic [12:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_wr,
    output logic        cpu_reset_n,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, LOAD, RUN, ERR
`ifdef LOADER_CHECKSUM_EN
        , CHK
`endif
    } state_t;

    state_t      state, state_next;
    logic        xfer;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [13:0] len_end;
    logic        len_bad;
    logic [13:0] remaining;
    logic        last_byte;
    logic        accept_next;
    logic        stay_run;
    logic        write_byte;
    logic        enter_load;
    logic        rearm;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign xfer      = in_valid && in_ready;
    assign len       = {len_hi, in_data};
    assign len_end   = {1'b0, BASE_ADDR} + len[13:0];
    // A full 8 KB image (0x2000) is legal, so only bits above 13 reject outright; the sum catches the rest.
    assign len_bad   = (len[15:14] != 2'b00) || (len_end > 14'd8192);
    assign last_byte = (remaining == 14'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (xfer && in_data == SYNC_BYTE) state_next = LEN_HI;
            LEN_HI: if (xfer) state_next = LEN_LO;
            LEN_LO: begin
                if (xfer) begin
                    if (len_bad)
                        state_next = ERR;
                    else if (len == 16'd0)
`ifdef LOADER_CHECKSUM_EN
                        state_next = CHK;
`else
                        state_next = RUN;
`endif
                    else
                        state_next = LOAD;
                end
            end
            LOAD: begin
                if (xfer && last_byte)
`ifdef LOADER_CHECKSUM_EN
                    state_next = CHK;
`else
                    state_next = RUN;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            CHK:    if (xfer) state_next = (in_data == csum) ? RUN : ERR;
`endif
            RUN:    if (halt) state_next = IDLE;
            ERR:    state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept_next = !(state_next == RUN || state_next == ERR);
        stay_run    = (state == RUN) && (state_next == RUN);
        write_byte  = (state == LOAD) && xfer;
        enter_load  = (state == LEN_LO) && (state_next == LOAD);
        rearm       = (state == RUN) && (state_next == IDLE);
    end

    // CPU release lags the RUN transition by one cycle so it never overlaps the final write strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready    <= 1'b0;
            mem_addr    <= BASE_ADDR;
            mem_wdata   <= '0;
            mem_wr      <= 1'b0;
            cpu_reset_n <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            len_hi      <= '0;
            remaining   <= '0;
        end else begin
            in_ready    <= accept_next;
            mem_wr      <= write_byte;
            cpu_reset_n <= stay_run;
            done        <= stay_run;
            error       <= error || (state_next == ERR);
            if (write_byte)
                mem_wdata <= in_data;
            if (state == LEN_HI && xfer)
                len_hi <= in_data;
            if (enter_load || rearm)
                mem_addr <= BASE_ADDR;
            else if (mem_wr)
                mem_addr <= mem_addr + 13'd1;
            if (enter_load)
                remaining <= len[13:0];
            else if (write_byte)
                remaining <= remaining - 14'd1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum <= '0;
        end else if (state == LEN_LO) begin
            csum <= '0;
        end else if (write_byte) begin
            csum <= csum ^ in_data;
        end
    end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes are queued as payload is driven
// and popped against each observed mem_wr strobe.
module tb_prog_loader;

    localparam logic [12:0] BASE = 13'h0000;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        halt;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wr;
    logic        cpu_reset_n;
    logic        done;
    logic        error;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [20:0] exp_q[$];

    prog_loader #(
        .BASE_ADDR(BASE),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .halt       (halt),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wr     (mem_wr),
        .cpu_reset_n(cpu_reset_n),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && mem_wr === 1'b1) begin
            check("wr_vs_cpu_run", 32'(cpu_reset_n), 32'd0);
            if (exp_q.size() == 0)
                check("unexpected_wr", {11'd0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
            else
                check("wr", {11'd0, mem_addr, mem_wdata}, 32'(exp_q.pop_front()));
        end
    end

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic pay(input logic [7:0] b, input int idx);
        exp_q.push_back({BASE + 13'(idx), b});
        send(b);
    endtask

    task automatic trail(input logic [7:0] b);
        if (CSUM) send(b);
    endtask

    task automatic gap();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic header(input logic [15:0] len);
        send(8'hA5);
        send(len[15:8]);
        send(len[7:0]);
    endtask

    task automatic expect_run(input string tag);
        in_valid = 1'b0;
        check({tag, "_cpu_held"}, 32'(cpu_reset_n), 32'd0);
        @(negedge clk);
        check({tag, "_cpu_rst_n"}, 32'(cpu_reset_n), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_halt();
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        check("halt_cpu_rst_n", 32'(cpu_reset_n), 32'd0);
        check("halt_done", 32'(done), 32'd0);
        check("halt_ready", 32'(in_ready), 32'd1);
        check("halt_addr", 32'(mem_addr), 32'(BASE));
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_cpu_rst_n", 32'(cpu_reset_n), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'(BASE));
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("rel_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] x;
        logic [7:0] b;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        halt     = 1'b0;
        #12;
        check("init_ready", 32'(in_ready), 32'd0);
        check("init_addr", 32'(mem_addr), 32'(BASE));
        check("init_wdata", 32'(mem_wdata), 32'd0);
        check("init_mem_wr", 32'(mem_wr), 32'd0);
        check("init_cpu_rst_n", 32'(cpu_reset_n), 32'd0);
        check("init_done", 32'(done), 32'd0);
        check("init_error", 32'(error), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        check("init_rel_ready", 32'(in_ready), 32'd0);
        @(negedge clk);

        // basic three-byte image, continuous valid
        header(16'd3);
        pay(8'h11, 0);
        pay(8'h22, 1);
        pay(8'h33, 2);
        trail(8'h00);
        expect_run("basic");

        // stream is ignored while running
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (3) @(negedge clk);
        check("run_ignore_ready", 32'(in_ready), 32'd0);
        check("run_ignore_cpu", 32'(cpu_reset_n), 32'd1);
        in_valid = 1'b0;

        // halt re-arm and second image
        do_halt();
        header(16'd1);
        pay(8'h7E, 0);
        trail(8'h7E);
        expect_run("rearm");

        // leading garbage, halt ignored in IDLE, valid toggled every other cycle
        do_halt();
        halt = 1'b1;
        send(8'h00); gap();
        send(8'hFF); gap();
        halt = 1'b0;
        check("garbage_idle_cpu", 32'(cpu_reset_n), 32'd0);
        send(8'hA5); gap();
        send(8'h00); gap();
        send(8'h03); gap();
        pay(8'h01, 0); gap();
        pay(8'h02, 1); gap();
        pay(8'h04, 2);
        trail(8'h07);
        expect_run("bp");

        // zero-length image
        do_halt();
        header(16'd0);
        trail(8'h00);
        expect_run("zero");

        // reset after 2 of 5 payload bytes, then a fresh frame
        do_halt();
        header(16'd5);
        pay(8'hC1, 0);
        pay(8'hC2, 1);
        do_reset();
        check("midload_sb_empty", 32'(exp_q.size()), 32'd0);
        header(16'd2);
        pay(8'hAA, 0);
        pay(8'hBB, 1);
        trail(8'h11);
        expect_run("after_rst");

        // full 8 KB image, last write at 1FFF
        do_reset();
        header(16'h2000);
        x = 8'h00;
        for (int i = 0; i < 8192; i++) begin
            b = 8'(i) ^ 8'(i >> 8);
            x = x ^ b;
            pay(b, i);
        end
        trail(x);
        expect_run("full");

        // one byte over the memory size
        do_reset();
        header(16'h2001);
        in_valid = 1'b0;
        check("over_error", 32'(error), 32'd1);
        check("over_ready", 32'(in_ready), 32'd0);
        check("over_cpu", 32'(cpu_reset_n), 32'd0);
        repeat (3) @(negedge clk);
        check("over_sticky", 32'(error), 32'd1);

        // high length bits set
        do_reset();
        header(16'h4000);
        in_valid = 1'b0;
        check("hibits_error", 32'(error), 32'd1);
        check("hibits_ready", 32'(in_ready), 32'd0);

        if (CSUM) begin
            do_reset();
            header(16'd2);
            pay(8'h0F, 0);
            pay(8'hF0, 1);
            send(8'hFF);
            expect_run("csum_ok");

            do_reset();
            header(16'd2);
            pay(8'h0F, 0);
            pay(8'hF0, 1);
            send(8'h00);
            in_valid = 1'b0;
            check("csum_bad_error", 32'(error), 32'd1);
            check("csum_bad_cpu", 32'(cpu_reset_n), 32'd0);
            @(negedge clk);
            check("csum_bad_cpu_held", 32'(cpu_reset_n), 32'd0);
            check("csum_bad_sb_empty", 32'(exp_q.size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
